// File: rtl/coil_pio_master.sv
// -----------------------------------------------------------------------------
// coil_pio_master
//   Single-outstanding command master for a small Avalon-MM register slave
//   (typical use: coil driver PIO block). A command is accepted in IDLE, turned
//   into one Avalon-MM access and completed with a one-cycle response pulse.
//   SET and CLEAR are fixed-address writes to registers 4 and 5 carrying a
//   bit mask. Reads use a fixed slave latency; stalled accesses are abandoned
//   after TIMEOUT waitrequest cycles.
//
// Parameters
//   ADDR_W        Avalon-MM address width
//   DATA_W        command / write / read data width
//   READ_LATENCY  slave read latency after the accept cycle (0..3)
//   TIMEOUT       stalled ACCESS cycles before abandoning (1..65535)
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op                  00 WRITE, 01 READ, 10 SET, 11 CLEAR
//   cmd_addr, cmd_data      target address (WRITE/READ), data or bit mask
//   avm_*                   Avalon-MM master port
//   rsp_valid               one-cycle completion pulse
//   rsp_data, rsp_timeout   read data / abandon flag, held until next response
// -----------------------------------------------------------------------------
module coil_pio_master #(
   parameter int unsigned ADDR_W       = 3,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic              avm_read_n,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [1:0]        OP_READ  = 2'b01;
   localparam logic [1:0]        OP_SET   = 2'b10;
   localparam logic [1:0]        OP_CLEAR = 2'b11;
   localparam logic [ADDR_W-1:0] SET_ADDR = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] CLR_ADDR = ADDR_W'(5);
   // Comparing the pre-increment count lets the access end after exactly
   // TIMEOUT stalled cycles, with the strobes dropping in the following cycle.
   localparam logic [15:0]       STALL_LAST = 16'(TIMEOUT - 1);
   localparam logic [1:0]        RD_LAT     = 2'(READ_LATENCY);

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                is_read_q, is_read_d;
   logic [15:0]         stall_q, stall_d;
   logic [1:0]          lat_q, lat_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                timeout_q, timeout_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_read_q <= 1'b0;
         stall_q   <= '0;
         lat_q     <= '0;
         rdata_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_read_q <= is_read_d;
         stall_q   <= stall_d;
         lat_q     <= lat_d;
         rdata_q   <= rdata_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      is_read_d = is_read_q;
      stall_d   = stall_q;
      lat_d     = lat_q;
      rdata_d   = rdata_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d   = ACCESS;
               wdata_d   = cmd_data;
               is_read_d = (cmd_op == OP_READ);
               stall_d   = '0;
               case (cmd_op)
                  OP_SET:   addr_d = SET_ADDR;
                  OP_CLEAR: addr_d = CLR_ADDR;
                  default:  addr_d = cmd_addr;
               endcase
            end
         end

         ACCESS: begin
            if (avm_waitrequest) begin
               stall_d = stall_q + 16'd1;
               if (stall_q == STALL_LAST) begin
                  state_d   = RESP;
                  rdata_d   = '0;
                  timeout_d = 1'b1;
               end
            end else if (is_read_q) begin
               if (RD_LAT == 2'd0) begin
                  state_d   = RESP;
                  rdata_d   = avm_readdata;
                  timeout_d = 1'b0;
               end else begin
                  state_d = RDWAIT;
                  lat_d   = 2'd1;
               end
            end else begin
               state_d   = RESP;
               rdata_d   = '0;
               timeout_d = 1'b0;
            end
         end

         // lat_q counts cycles since the accept cycle; data is taken when it
         // equals the configured latency.
         RDWAIT: begin
            if (lat_q == RD_LAT) begin
               state_d   = RESP;
               rdata_d   = avm_readdata;
               timeout_d = 1'b0;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered so that it stays low throughout reset and rises one edge
      // after release, and is already high in the cycle following RESP.
      ready_d = (state_d == IDLE);
   end

   assign cmd_ready      = ready_q;
   assign avm_address    = addr_q;
   assign avm_writedata  = wdata_q;
   assign avm_chipselect = (state_q == ACCESS);
   assign avm_write_n    = !((state_q == ACCESS) && !is_read_q);
   assign avm_read_n     = !((state_q == ACCESS) && is_read_q);
   assign rsp_valid      = (state_q == RESP);
   assign rsp_data       = rdata_q;
   assign rsp_timeout    = timeout_q;

endmodule

// File: tb/tb_coil_pio_master.sv
`timescale 1ns/1ps
module tb_coil_pio_master;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned RL = 1;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [AW-1:0] avm_address;
   logic          avm_chipselect;
   logic          avm_write_n;
   logic          avm_read_n;
   logic [DW-1:0] avm_writedata;
   logic [DW-1:0] avm_readdata = '0;
   logic          avm_waitrequest = 1'b0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_timeout;

   int unsigned checks = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   coil_pio_master #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Transaction-level reference: how many strobe cycles a command takes,
   // when its response appears (cycles after the command-accept edge) and
   // what it reports, given how many cycles the slave stalls.
   function automatic void model(input logic [1:0] op, input logic [AW-1:0] addr,
                                 input int unsigned waits, input logic [DW-1:0] rdata,
                                 output logic [AW-1:0] ea, output int unsigned strobes,
                                 output int unsigned lat, output logic [DW-1:0] ed,
                                 output logic eto);
      logic rd;
      rd      = (op == 2'b01);
      eto     = (waits >= TO);
      strobes = eto ? TO : waits + 1;
      ea      = (op == 2'b10) ? AW'(4) : (op == 2'b11) ? AW'(5) : addr;
      lat     = strobes + 1 + ((rd && !eto) ? RL : 0);
      ed      = (rd && !eto) ? rdata : '0;
   endfunction

   // Entered and left at a falling edge; DUT expected idle on entry.
   task automatic run_txn(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input int unsigned waits,
                          input logic [DW-1:0] rdata, input logic [AW-1:0] ea,
                          input int unsigned estrobes, input int unsigned elat,
                          input logic [DW-1:0] edata, input logic eto);
      int unsigned wait_cnt = 0, strobes = 0, cyc = 0, acc = 0, rsp_cyc = 0;
      int unsigned pulses = 0, bad = 0, busy_ready = 0;
      logic [DW-1:0] got_data = '0;
      logic got_to = 1'b0, seen = 1'b0, done = 1'b0, post_ready = 1'b0, hold_ok = 1'b0;
      while (!cmd_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      check({tag, ".ready_in"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      @(negedge clk);
      while (!done && cyc < 40) begin
         cyc++;
         if (avm_chipselect) begin
            strobes++;
            if (avm_address !== ea || avm_writedata !== data ||
                avm_write_n !== (op == 2'b01) || avm_read_n !== (op != 2'b01)) bad++;
            avm_waitrequest = (strobes <= waits);
            if (!avm_waitrequest) acc = cyc;
         end else begin
            if (avm_write_n !== 1'b1 || avm_read_n !== 1'b1) bad++;
            avm_waitrequest = 1'($urandom);
         end
         avm_readdata = (acc != 0 && cyc == acc + RL) ? rdata : DW'($urandom);
         if (seen) begin
            post_ready = cmd_ready;
            hold_ok = (rsp_data === got_data) && (rsp_timeout === got_to);
            if (rsp_valid) pulses++;
            done = 1'b1;
         end else begin
            if (cmd_ready !== 1'b0) busy_ready++;
            if (rsp_valid) begin
               seen = 1'b1; pulses++; rsp_cyc = cyc;
               got_data = rsp_data; got_to = rsp_timeout;
            end
         end
         // Commands offered while busy must be ignored.
         cmd_valid = !seen;
         cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_data = DW'($urandom);
         if (!done) @(negedge clk);
      end
      cmd_valid = 1'b0;
      check({tag, ".complete"},   64'(done),       64'd1);
      check({tag, ".strobes"},    64'(strobes),    64'(estrobes));
      check({tag, ".rsp_cycle"},  64'(rsp_cyc),    64'(elat));
      check({tag, ".rsp_data"},   64'(got_data),   64'(edata));
      check({tag, ".rsp_to"},     64'(got_to),     64'(eto));
      check({tag, ".pulses"},     64'(pulses),     64'd1);
      check({tag, ".bus_bad"},    64'(bad),        64'd0);
      check({tag, ".busy_ready"}, 64'(busy_ready), 64'd0);
      check({tag, ".post_ready"}, 64'(post_ready), 64'd1);
      check({tag, ".rsp_hold"},   64'(hold_ok),    64'd1);
   endtask

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int unsigned   waits;
      logic [DW-1:0] rdata;
      logic [AW-1:0] ea;
      int unsigned   strobes;
      int unsigned   lat;
      logic [DW-1:0] edata;
      logic          eto;
   } vec_t;

   vec_t vt[11];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]    r_op;
      logic [AW-1:0] r_addr, r_ea;
      logic [DW-1:0] r_data, r_rdata, r_ed;
      int unsigned   r_waits, r_str, r_lat, pulses;
      logic          r_to;

      //            op     addr  data           waits rdata          ea    str lat edata          to
      vt[0]  = '{2'b00, 3'd0, 32'h0000_0001, 0,  32'h0,         3'd0, 1, 2, 32'h0,         1'b0};
      vt[1]  = '{2'b10, 3'd7, 32'h0000_0001, 0,  32'h0,         3'd4, 1, 2, 32'h0,         1'b0};
      vt[2]  = '{2'b11, 3'd2, 32'h0000_0001, 0,  32'h0,         3'd5, 1, 2, 32'h0,         1'b0};
      vt[3]  = '{2'b01, 3'd0, 32'h0,         0,  32'h0000_0001, 3'd0, 1, 3, 32'h0000_0001, 1'b0};
      vt[4]  = '{2'b00, 3'd3, 32'hDEAD_BEEF, 3,  32'h0,         3'd3, 4, 5, 32'h0,         1'b0};
      vt[5]  = '{2'b01, 3'd6, 32'h0,         3,  32'h0000_A5A5, 3'd6, 4, 6, 32'h0000_A5A5, 1'b0};
      vt[6]  = '{2'b00, 3'd1, 32'h1234_5678, 4,  32'h0,         3'd1, 4, 5, 32'h0,         1'b1};
      vt[7]  = '{2'b01, 3'd7, 32'h0,         9,  32'h0000_CAFE, 3'd7, 4, 5, 32'h0,         1'b1};
      vt[8]  = '{2'b01, 3'd2, 32'h0,         2,  32'hFFFF_FFFF, 3'd2, 3, 5, 32'hFFFF_FFFF, 1'b0};
      vt[9]  = '{2'b10, 3'd5, 32'h8000_0000, 10, 32'h0,         3'd4, 4, 5, 32'h0,         1'b1};
      vt[10] = '{2'b11, 3'd0, 32'h0000_00F0, 1,  32'h0,         3'd5, 2, 3, 32'h0,         1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.cmd_ready",   64'(cmd_ready),      64'd0);
      check("rst.chipselect",  64'(avm_chipselect), 64'd0);
      check("rst.write_n",     64'(avm_write_n),    64'd1);
      check("rst.read_n",      64'(avm_read_n),     64'd1);
      check("rst.address",     64'(avm_address),    64'd0);
      check("rst.writedata",   64'(avm_writedata),  64'd0);
      check("rst.rsp_valid",   64'(rsp_valid),      64'd0);
      check("rst.rsp_data",    64'(rsp_data),       64'd0);
      check("rst.rsp_timeout", 64'(rsp_timeout),    64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst.ready_after_release", 64'(cmd_ready), 64'd1);

      // Directed vectors
      for (int i = 0; i < 11; i++)
         run_txn($sformatf("vec%0d", i), vt[i].op, vt[i].addr, vt[i].data, vt[i].waits,
                 vt[i].rdata, vt[i].ea, vt[i].strobes, vt[i].lat, vt[i].edata, vt[i].eto);

      // Randomized commands against the reference model
      for (int i = 0; i < 60; i++) begin
         r_op    = 2'($urandom);
         r_addr  = AW'($urandom);
         r_data  = DW'($urandom);
         r_rdata = DW'($urandom);
         r_waits = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 8) : $urandom_range(0, 2);
         model(r_op, r_addr, r_waits, r_rdata, r_ea, r_str, r_lat, r_ed, r_to);
         run_txn($sformatf("rnd%0d", i), r_op, r_addr, r_data, r_waits, r_rdata,
                 r_ea, r_str, r_lat, r_ed, r_to);
      end

      // Reset in the middle of a stalled access
      avm_waitrequest = 1'b1;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 3'd3; cmd_data = 32'h77;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("mr.in_access", 64'(avm_chipselect), 64'd1);
      reset_n = 1'b0;
      #1;
      check("mr.chipselect", 64'(avm_chipselect), 64'd0);
      check("mr.write_n",    64'(avm_write_n),    64'd1);
      check("mr.read_n",     64'(avm_read_n),     64'd1);
      check("mr.address",    64'(avm_address),    64'd0);
      check("mr.rsp_data",   64'(rsp_data),       64'd0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      check("mr.no_rsp", 64'(pulses), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("mr.ready",     64'(cmd_ready), 64'd1);
      check("mr.rsp_after", 64'(rsp_valid), 64'd0);
      avm_waitrequest = 1'b0;
      run_txn("mr.post", 2'b00, 3'd2, 32'h0000_0042, 0, 32'h0, 3'd2, 1, 2, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
